// File: rtl/multi_channel_cycle_timer.sv
// multi_channel_cycle_timer
//
// CHANNELS independent down-counting timers, each BIT_WIDTH bits wide and
// individually selectable as one-shot or periodic (auto-reload). All channels
// advance on a shared tick. The tick comes either from an optional shared
// prescaler (compiled in with MULTI_CHANNEL_CYCLE_TIMER_PRESCALER_EN) or is
// asserted every cycle when that macro is undefined.
//
// Ports:
//   clock             - single clock, rising-edge active
//   reset             - synchronous, active-high
//   enable            - per-channel enable; gates both load and decrement
//   load_count        - per-channel load strobe (honoured only when enabled)
//   count             - per-channel load values, channel i at [i*BIT_WIDTH +: BIT_WIDTH]
//   periodic          - per-channel mode: 0 = one-shot, 1 = auto-reload
//   prescale          - shared tick divisor, tick period = prescale+1 cycles
//                       (ignored when the prescaler is compiled out)
//   expired           - level, bit i high while counter i is zero
//   expired_pulse     - registered one-cycle pulse when channel i completes a count
//   any_expired_pulse - OR of expired_pulse

module multi_channel_cycle_timer #(
    parameter int CHANNELS       = 4,
    parameter int BIT_WIDTH      = 16,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [CHANNELS-1:0]           enable,
    input  logic [CHANNELS-1:0]           load_count,
    input  logic [CHANNELS*BIT_WIDTH-1:0] count,
    input  logic [CHANNELS-1:0]           periodic,
    input  logic [PRESCALE_WIDTH-1:0]     prescale,
    output logic [CHANNELS-1:0]           expired,
    output logic [CHANNELS-1:0]           expired_pulse,
    output logic                          any_expired_pulse
);

    localparam logic [BIT_WIDTH-1:0] ONE = BIT_WIDTH'(1);

    logic tick;

`ifdef MULTI_CHANNEL_CYCLE_TIMER_PRESCALER_EN
    logic [PRESCALE_WIDTH-1:0] prescale_cnt_q;
    logic [PRESCALE_WIDTH-1:0] prescale_cnt_d;

    // Free-running divider. Using >= rather than == means lowering prescale
    // below the current count wraps on the next cycle instead of rolling
    // all the way around the counter range.
    always_comb begin
        tick           = (prescale_cnt_q >= prescale);
        prescale_cnt_d = tick ? '0 : prescale_cnt_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prescale_cnt_q <= '0;
        end else begin
            prescale_cnt_q <= prescale_cnt_d;
        end
    end
`else
    logic unused_prescale;

    assign unused_prescale = ^prescale;
    assign tick            = 1'b1;
`endif

    logic [CHANNELS-1:0][BIT_WIDTH-1:0] counter_q;
    logic [CHANNELS-1:0][BIT_WIDTH-1:0] counter_d;
    logic [CHANNELS-1:0][BIT_WIDTH-1:0] reload_q;
    logic [CHANNELS-1:0][BIT_WIDTH-1:0] reload_d;
    logic [CHANNELS-1:0]                pulse_q;
    logic [CHANNELS-1:0]                pulse_d;

    always_comb begin
        counter_d = counter_q;
        reload_d  = reload_q;
        pulse_d   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (enable[i] && load_count[i]) begin
                // Load takes priority over a same-cycle tick, so a load
                // landing on the counter==1 tick suppresses that pulse.
                counter_d[i] = count[i*BIT_WIDTH +: BIT_WIDTH];
                reload_d[i]  = count[i*BIT_WIDTH +: BIT_WIDTH];
            end else if (enable[i] && tick) begin
                if (counter_q[i] > ONE) begin
                    counter_d[i] = counter_q[i] - ONE;
                end else if (counter_q[i] == ONE) begin
                    // Completion happens on the 1 -> 0/reload step, so a
                    // counter parked at zero never pulses again.
                    pulse_d[i]   = 1'b1;
                    counter_d[i] = periodic[i] ? reload_q[i] : '0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            counter_q <= '0;
            reload_q  <= '0;
            pulse_q   <= '0;
        end else begin
            counter_q <= counter_d;
            reload_q  <= reload_d;
            pulse_q   <= pulse_d;
        end
    end

    always_comb begin
        expired = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            expired[i] = (counter_q[i] == '0);
        end
    end

    assign expired_pulse     = pulse_q;
    assign any_expired_pulse = |pulse_q;

endmodule

// File: tb/tb_multi_channel_cycle_timer.sv
// Self-checking bench for multi_channel_cycle_timer: a few directed
// scenarios followed by randomized traffic, every cycle compared against a
// behavioural model of the timer rules.
module tb_multi_channel_cycle_timer;

    localparam int CH = 4;
    localparam int BW = 16;
    localparam int PW = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic [CH-1:0]    enable;
    logic [CH-1:0]    load_count;
    logic [CH*BW-1:0] count;
    logic [CH-1:0]    periodic;
    logic [PW-1:0]    prescale;
    logic [CH-1:0]    expired;
    logic [CH-1:0]    expired_pulse;
    logic             any_expired_pulse;

    int total = 0;
    int bad   = 0;

    // Model state
    int unsigned m_cnt [CH];
    int unsigned m_rel [CH];
    bit          m_pul [CH];
    int unsigned m_pre;

    multi_channel_cycle_timer #(
        .CHANNELS(CH), .BIT_WIDTH(BW), .PRESCALE_WIDTH(PW)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .load_count(load_count),
        .count(count), .periodic(periodic), .prescale(prescale),
        .expired(expired), .expired_pulse(expired_pulse),
        .any_expired_pulse(any_expired_pulse)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One rising edge of the timer rules, applied to the inputs as they
    // stand just before the edge.
    task automatic model_edge();
        bit tk;
`ifdef MULTI_CHANNEL_CYCLE_TIMER_PRESCALER_EN
        tk = (m_pre >= int'(prescale));
        if (reset)   m_pre = 0;
        else if (tk) m_pre = 0;
        else         m_pre = m_pre + 1;
`else
        tk = 1'b1;
`endif
        for (int i = 0; i < CH; i++) begin
            if (reset) begin
                m_cnt[i] = 0; m_rel[i] = 0; m_pul[i] = 0;
            end else if (enable[i] && load_count[i]) begin
                m_cnt[i] = count[i*BW +: BW];
                m_rel[i] = m_cnt[i];
                m_pul[i] = 0;
            end else if (enable[i] && tk && m_cnt[i] > 1) begin
                m_cnt[i] = m_cnt[i] - 1;
                m_pul[i] = 0;
            end else if (enable[i] && tk && m_cnt[i] == 1) begin
                m_pul[i] = 1;
                m_cnt[i] = periodic[i] ? m_rel[i] : 0;
            end else begin
                m_pul[i] = 0;
            end
        end
    endtask

    task automatic step();
        logic [CH-1:0] e_exp, e_pul;
        @(posedge clock);
        model_edge();
        #1;
        for (int i = 0; i < CH; i++) begin
            e_exp[i] = (m_cnt[i] == 0);
            e_pul[i] = m_pul[i];
        end
        check_eq("model_expired", 64'(expired), 64'(e_exp));
        check_eq("model_pulse", 64'(expired_pulse), 64'(e_pul));
        check_eq("model_any", 64'(any_expired_pulse), 64'(|e_pul));
    endtask

    task automatic set_count(input int ch, input int unsigned v);
        count[ch*BW +: BW] = BW'(v);
    endtask

    initial begin
        m_pre = 0;
        for (int i = 0; i < CH; i++) begin
            m_cnt[i] = 0; m_rel[i] = 0; m_pul[i] = 0;
        end
        reset = 1'b1; enable = '0; load_count = '0; count = '0;
        periodic = '0; prescale = '0;
        step(); step();
        check_eq("reset_expired", 64'(expired), 64'hF);
        check_eq("reset_pulse", 64'(expired_pulse), 64'h0);
        reset = 1'b0;
        step();
        check_eq("idle_expired", 64'(expired), 64'hF);

        // Channel 0 one-shot load of 5
        enable = 4'hF;
        load_count = 4'b0001; set_count(0, 5);
        step();
        load_count = '0;
        check_eq("ch0_loaded", 64'(expired[0]), 64'h0);
        for (int k = 1; k <= 6; k++) begin
            step();
            check_eq("ch0_pulse", 64'(expired_pulse[0]), 64'(k == 5));
            check_eq("ch0_expired", 64'(expired[0]), 64'(k >= 5));
        end

        // Channel 1 periodic reload 3
        periodic = 4'b0010;
        load_count = 4'b0010; set_count(1, 3);
        step();
        load_count = '0;
        for (int k = 1; k <= 10; k++) begin
            step();
            check_eq("ch1_pulse", 64'(expired_pulse[1]), 64'(k % 3 == 0 && k < 10));
            check_eq("ch1_expired", 64'(expired[1]), 64'h0);
        end
        periodic = '0;
        step(); step(); step(); step();

        // Channel 2: freeze mid-count, ignored load while disabled
        load_count = 4'b0100; set_count(2, 4);
        step();
        load_count = '0;
        step(); step();
        enable[2] = 1'b0;
        load_count = 4'b0100; set_count(2, 9);
        step(); step(); step();
        load_count = '0;
        enable[2] = 1'b1;
        step();
        check_eq("ch2_resume_pulse", 64'(expired_pulse[2]), 64'h0);
        step();
        check_eq("ch2_done_pulse", 64'(expired_pulse[2]), 64'h1);
        check_eq("ch2_done_expired", 64'(expired[2]), 64'h1);

        // Channel 3: load on the counter==1 tick wins, then load of zero
        load_count = 4'b1000; set_count(3, 2);
        step();
        load_count = '0;
        step();
        load_count = 4'b1000; set_count(3, 7);
        step();
        load_count = '0;
        check_eq("ch3_load_beats_pulse", 64'(expired_pulse[3]), 64'h0);
        check_eq("ch3_reloaded", 64'(expired[3]), 64'h0);
        load_count = 4'b1000; set_count(3, 0);
        step();
        load_count = '0;
        check_eq("ch3_zero_expired", 64'(expired[3]), 64'h1);
        check_eq("ch3_zero_pulse", 64'(expired_pulse[3]), 64'h0);

        // Reset mid-count on all channels; periodic reload must be gone too
        periodic = 4'hF;
        load_count = 4'hF;
        for (int i = 0; i < CH; i++) set_count(i, 6);
        step();
        load_count = '0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("midreset_expired", 64'(expired), 64'hF);
        check_eq("midreset_pulse", 64'(expired_pulse), 64'h0);
        for (int k = 0; k < 8; k++) step();
        check_eq("post_reset_periodic_idle", 64'(expired), 64'hF);

        // Prescaled one-shot; the model tracks the free-running phase
        prescale = 8'd2; periodic = '0;
        load_count = 4'b0001; set_count(0, 3);
        step();
        load_count = '0;
        for (int k = 0; k < 12; k++) step();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < CH; i++) begin
                enable[i]     = ($urandom_range(0, 9) != 0);
                load_count[i] = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 19) == 0) periodic[i] = ~periodic[i];
                if ($urandom_range(0, 15) == 0) set_count(i, $urandom_range(0, 1));
                else                            set_count(i, $urandom_range(0, 7));
            end
            if ($urandom_range(0, 49) == 0) prescale = PW'($urandom_range(0, 3));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_channel_cycle_timer.md
# multi_channel_cycle_timer

Parametrised successor to the single-channel down-counting cycle timer. It provides CHANNELS independent timers, each BIT_WIDTH bits wide, and each selectable as one-shot or periodic (auto-reload). Every channel has a level `expired` output and a single-cycle expiry pulse. A shared tick prescaler can be compiled in. Switch-level control logic uses it for per-port timeouts, retry back-off and periodic housekeeping strobes from one block.

## Interface

Parameters:
- CHANNELS, 4, number of independent timer channels (≥1)
- BIT_WIDTH, 16, width of each channel counter and load value (≥2)
- PRESCALE_WIDTH, 8, width of the shared prescaler divisor (≥1)

Ports (clock and reset first):
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  reset is synchronous and active-high
- enable  input  CHANNELS  per-channel enable; gates load and decrement
- load_count  input  CHANNELS  per-channel load strobe; honoured only when that channel's enable=1
- count  input  CHANNELS*BIT_WIDTH  per-channel load value; channel i at [i*BIT_WIDTH +: BIT_WIDTH]
- periodic  input  CHANNELS  per-channel mode: 0=one-shot, 1=auto-reload; sampled every cycle
- prescale  input  PRESCALE_WIDTH  shared tick divisor; tick period = prescale+1 cycles
- expired  output  CHANNELS  level; bit i = (counter[i]==0), combinational from register
- expired_pulse  output  CHANNELS  registered; 1-cycle pulse when channel i completes a count
- any_expired_pulse  output  1  OR-reduction of expired_pulse

## Operation

- Per-channel state: counter[i] (BIT_WIDTH) and reload[i] (BIT_WIDTH).
- Shared tick: with prescaler compiled out, tick=1 every cycle.
- Channel i next state, in priority order:
  1. reset: counter=0, reload=0, pulse=0.
  2. enable=1 & load_count=1: counter=count_i, reload=count_i, pulse=0. Load beats a same-cycle tick. Loading 0 gives expired=1 next cycle with no pulse.
  3. enable=1 & tick & counter>1: counter=counter-1, pulse=0.
  4. enable=1 & tick & counter==1: pulse=1. If one-shot, counter=0. If periodic, counter=reload.
  5. Otherwise: hold, pulse=0. This includes counter==0, enable=0, and no tick.
- enable=0 freezes the counter mid-count and ignores load_count. Asserting enable again resumes from the held value.
- Changing periodic mid-count takes effect at the next counter==1 tick. The reload value is not changed.
- Arithmetic is unsigned. The counter never wraps below 0 because decrement happens only when counter>1.
- Channels are fully independent. Multiple channels may pulse in the same cycle.

## Timing

- Reset values: expired = all ones, expired_pulse = 0, any_expired_pulse = 0, prescaler count = 0.
- Load latency: the counter holds count_i after the loading edge, and expired reflects it in the same cycle.
- One-shot with prescale=0: a load of N at edge E puts the counter at 0 after edge E+N. Expired rises and expired_pulse is high for exactly the cycle after edge E+N.
- Periodic with reload N≥1 and prescale=0: expired_pulse fires every N cycles. The counter sequence is N…1,N…1 and expired stays 0.
- Periodic with reload=1 gives a pulse every tick. Periodic with reload=0 behaves as a one-shot that has already expired.
- Reset asserted mid-count clears the channel on that edge, with no pulse.
- Simultaneous load and counter==1 tick: the load wins and no pulse is produced.

## Configuration

- Macro: MULTI_CHANNEL_CYCLE_TIMER_PRESCALER_EN.
- With the macro defined:
  - A free-running shared prescaler counter (PRESCALE_WIDTH bits) counts from 0 upward.
  - tick=1 when the prescaler count ≥ prescale, and the prescaler returns to 0 on that cycle. Otherwise it increments.
  - prescale=0 gives a tick every cycle. Lowering prescale below the current count wraps on the next cycle.
  - The prescaler runs regardless of the channel enables and resets to 0.
- With the macro undefined:
  - No prescaler logic is built and tick=1 every cycle.
  - The prescale port remains and is ignored.

## Test plan

- Reset then idle: expired = all ones, pulses 0. Load ch0=5 one-shot: the counter reads 5,4,3,2,1,0 and expired_pulse[0] is high exactly once, in the cycle expired[0] rises.
- Ch1 periodic load 3 for 10 cycles: expired_pulse[1] fires at cycles 3, 6, 9 after the load, and expired[1] stays 0 throughout.
- Ch2 load 4, then deassert enable for 3 cycles after two decrements: the counter holds at 2, then completes 2 cycles after enable returns. load_count issued while enable=0 is ignored.
- Ch3 reaches 1 and load_count=1 with count=7 is asserted on the same cycle: the counter becomes 7 and there is no pulse. Loading 0 gives expired[3]=1 with no pulse.
- Reset asserted mid-count on all channels: on the next cycle expired = all ones, expired_pulse=0, and any reload is cleared. A subsequent periodic channel with no new load stays expired.
- With the prescaler enabled, prescale=2 and ch0 one-shot load 3: the pulse occurs 9 cycles after the load (±phase of a free-running prescaler, checked against a model).
